// File: rtl/vme_cmd_executor_pkg.sv
// rtl/vme_cmd_executor_pkg.sv - command/response bit positions, FSM states, response packing
package vme_cmd_executor_pkg;

   localparam int CMD_ADDR_LSB = 0;
   localparam int CMD_ADDR_MSB = 15;
   localparam int CMD_TAG_LSB  = 16;
   localparam int CMD_TAG_MSB  = 23;
   localparam int CMD_WR       = 24;
   localparam int CMD_RD       = 25;

   localparam int RSP_TIMEOUT  = 16;
   localparam int RSP_BADCMD   = 17;
   localparam int RSP_SEQ_LSB  = 24;
   localparam int RSP_SEQ_MSB  = 31;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   function automatic logic [31:0] build_resp(input logic [7:0]  seq,
                                              input logic        bad_cmd,
                                              input logic        timeout,
                                              input logic [15:0] data);
      return {seq, 6'b000000, bad_cmd, timeout, data};
   endfunction

endpackage

// File: rtl/vme_cmd_executor_if.sv
// rtl/vme_cmd_executor_if.sv - VME command handshake plus 16-bit register bus bundle
interface vme_cmd_executor_if;
   logic        start;
   logic [31:0] vme_cmd_reg;
   logic [31:0] vme_dat_reg_in;
   logic        vme_cmd_rd;
   logic        vme_dat_wr;
   logic [31:0] vme_dat_reg_out;
   logic [15:0] bus_addr;
   logic [15:0] bus_wdata;
   logic        bus_we;
   logic        bus_re;
   logic        bus_ack;
   logic [15:0] bus_rdata;

   // master: command driver and register decoders; slave: the executor
   modport master (
      output start, vme_cmd_reg, vme_dat_reg_in, bus_ack, bus_rdata,
      input  vme_cmd_rd, vme_dat_wr, vme_dat_reg_out, bus_addr, bus_wdata, bus_we, bus_re
   );

   modport slave (
      input  start, vme_cmd_reg, vme_dat_reg_in, bus_ack, bus_rdata,
      output vme_cmd_rd, vme_dat_wr, vme_dat_reg_out, bus_addr, bus_wdata, bus_we, bus_re
   );
endinterface

// File: rtl/vme_cmd_timer.sv
// rtl/vme_cmd_timer.sv - loadable 8-bit down-counter; expire flags the last enabled cycle
module vme_cmd_timer (
   input  logic       clk,
   input  logic       rst,
   input  logic       clear_i,
   input  logic       load_i,
   input  logic [7:0] load_val_i,
   input  logic       en_i,
   output logic       expire_o
);

   logic [7:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = 8'd0;
      end else if (load_i) begin
         cnt_d = load_val_i;
      end else if (en_i && (cnt_q != 8'd0)) begin
         cnt_d = cnt_q - 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= 8'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = en_i && (cnt_q == 8'd1);

endmodule

// File: rtl/vme_cmd_executor.sv
// rtl/vme_cmd_executor.sv - validates a VME command word, runs one register-bus transfer, returns a response
module vme_cmd_executor
   import vme_cmd_executor_pkg::*;
#(
   parameter logic [7:0] BOARD_TAG      = 8'hA8,
   parameter int         TIMEOUT_CYCLES = 255
) (
   input logic               clk,
   input logic               rst,
   vme_cmd_executor_if.slave vme_if
);

   localparam logic [7:0] TMO_LOAD = TIMEOUT_CYCLES[7:0];

   state_e      state_q, state_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic        rd_q, rd_d;
   logic        wr_q, wr_d;
   logic [31:0] resp_q, resp_d;
   logic [7:0]  seq_q, seq_d;
   logic        ready_q;

   logic        tmr_clear, tmr_load, tmr_en, tmr_expire;
   logic [7:0]  cmd_tag;
   logic        cmd_valid;
   logic        unused_bits;

   assign cmd_tag     = vme_if.vme_cmd_reg[CMD_TAG_MSB:CMD_TAG_LSB];
   assign cmd_valid   = (cmd_tag == BOARD_TAG) &&
                        (vme_if.vme_cmd_reg[CMD_WR] ^ vme_if.vme_cmd_reg[CMD_RD]);
   assign unused_bits = ^{vme_if.vme_cmd_reg[31:26], vme_if.vme_dat_reg_in[31:16]};

   vme_cmd_timer u_timer (
      .clk        (clk),
      .rst        (rst),
      .clear_i    (tmr_clear),
      .load_i     (tmr_load),
      .load_val_i (TMO_LOAD),
      .en_i       (tmr_en),
      .expire_o   (tmr_expire)
   );

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rd_d      = rd_q;
      wr_d      = wr_q;
      resp_d    = resp_q;
      seq_d     = seq_q;
      tmr_clear = 1'b0;
      tmr_load  = 1'b0;
      tmr_en    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (ready_q && vme_if.start) begin
               addr_d  = vme_if.vme_cmd_reg[CMD_ADDR_MSB:CMD_ADDR_LSB];
               wdata_d = vme_if.vme_dat_reg_in[15:0];
               if (cmd_valid) begin
                  rd_d     = vme_if.vme_cmd_reg[CMD_RD];
                  wr_d     = vme_if.vme_cmd_reg[CMD_WR];
                  tmr_load = 1'b1;
                  state_d  = ST_BUSY;
               end else begin
                  rd_d    = 1'b0;
                  wr_d    = 1'b0;
                  resp_d  = build_resp(seq_q, 1'b1, 1'b0, 16'h0000);
                  state_d = ST_RESP;
               end
            end
         end
         ST_BUSY: begin
            tmr_en = 1'b1;
            // ack wins over a coincident expiry
            if (vme_if.bus_ack) begin
               resp_d  = build_resp(seq_q, 1'b0, 1'b0, rd_q ? vme_if.bus_rdata : wdata_q);
               state_d = ST_RESP;
            end else if (tmr_expire) begin
               resp_d  = build_resp(seq_q, 1'b0, 1'b1, 16'h0000);
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            seq_d     = seq_q + 8'd1;
            tmr_clear = 1'b1;
            state_d   = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         addr_q  <= 16'h0000;
         wdata_q <= 16'h0000;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         resp_q  <= 32'h0000_0000;
         seq_q   <= 8'd0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         resp_q  <= resp_d;
         seq_q   <= seq_d;
         ready_q <= 1'b1;
      end
   end

   // strobes decode from state so an asynchronous reset drops them at once
   assign vme_if.vme_cmd_rd      = ready_q && (state_q == ST_IDLE);
   assign vme_if.vme_dat_wr      = (state_q == ST_RESP);
   assign vme_if.vme_dat_reg_out = resp_q;
   assign vme_if.bus_addr        = addr_q;
   assign vme_if.bus_wdata       = wdata_q;
   assign vme_if.bus_re          = (state_q == ST_BUSY) && rd_q;
   assign vme_if.bus_we          = (state_q == ST_BUSY) && wr_q;

endmodule
